// File: rtl/isp_loader.sv
// isp_loader: UART (8N1) download engine that packs received bytes into
// little-endian 32-bit words and issues single-cycle RAM write strobes.
module isp_loader #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RXD,
    input  logic              ISPEN,
    output logic              WR,
    output logic [ADDR_W-1:0] WRADDR,
    output logic [31:0]       WRDATA,
    output logic              BUSY,
    output logic              FRAME_ERR
);

    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HALF   = (CLK_DIV / 2 > 0) ? CLK_DIV / 2 : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic              rxd_meta;
    logic              rxd_sync;
    logic              rxd_prev;
    logic              rxd_fall;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              byte_vld;

    logic [1:0]        lane;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign rxd_fall = rxd_prev & ~rxd_sync;

    // Receive FSM: start-bit qualification at mid-bit, 8 data bits LSB first, stop check
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else if (!ISPEN) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_vld  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (rxd_fall) begin
                        state <= START;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        // A high line at mid start bit is a glitch: drop it silently
                        state    <= rxd_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {rxd_sync, shreg[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (rxd_sync) begin
                            byte_vld <= 1'b1;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word assembly, write strobe and address sequencing
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lane   <= '0;
            word   <= '0;
            addr   <= '0;
            WR     <= 1'b0;
            WRADDR <= '0;
            WRDATA <= '0;
        end else if (!ISPEN) begin
            lane <= '0;
            word <= '0;
            addr <= '0;
            WR   <= 1'b0;
        end else begin
            WR <= 1'b0;
            if (WR) begin
                addr <= addr + ADDR_W'(1);
            end
            if (byte_vld) begin
                if (lane == 2'd3) begin
                    WR     <= 1'b1;
                    WRADDR <= addr;
                    WRDATA <= {shreg, word[23:0]};
                    word   <= '0;
                    lane   <= '0;
                end else begin
                    word[{lane, 3'b000} +: 8] <= shreg;
                    lane <= lane + 2'd1;
                end
            end
        end
    end

    // Busy while a byte is in flight or a partial word is held
    assign BUSY = (state != IDLE) || (lane != 2'd0);

endmodule
